// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if
//   Groups the fetch-side push port, the execute-side resolve port, the
//   predictor training outputs and the redirect outputs of the branch
//   resolve queue.
//   slave  : used by the queue itself
//   master : used by whatever drives the queue (fetch/execute model, bench)
interface branch_resolve_queue_if #(
    parameter int W_BRID = 2,
    parameter int W_ADDR = 32,
    parameter int W_PTR  = 2
);
    // fetch push side
    logic              push_v_i;
    logic [W_BRID-1:0] push_id_i;
    logic [W_ADDR-1:0] push_alt_pc_i;
    // occupancy status
    logic              full_o;
    logic              empty_o;
    logic [W_PTR:0]    count_o;
    // execute resolve side
    logic              res_v_i;
    logic              res_taken_i;
    logic              flush_i;
    // predictor training
    logic              upd_v_o;
    logic              upd_branch_o;
    logic [W_BRID-1:0] upd_id_o;
    // redirect to fetch
    logic              mispred_o;
    logic [W_ADDR-1:0] redirect_pc_o;
    logic              err_o;

    modport slave (
        input  push_v_i, push_id_i, push_alt_pc_i,
        input  res_v_i, res_taken_i, flush_i,
        output full_o, empty_o, count_o,
        output upd_v_o, upd_branch_o, upd_id_o,
        output mispred_o, redirect_pc_o, err_o
    );

    modport master (
        output push_v_i, push_id_i, push_alt_pc_i,
        output res_v_i, res_taken_i, flush_i,
        input  full_o, empty_o, count_o,
        input  upd_v_o, upd_branch_o, upd_id_o,
        input  mispred_o, redirect_pc_o, err_o
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   In-order queue between fetch-stage branch prediction and execute-stage
//   branch resolution. Each entry holds the predictor counter snapshot and
//   the PC of the not-predicted path. Resolution is oldest-first; every
//   accepted resolve trains the predictor one cycle later, and a
//   misprediction additionally raises a one-cycle redirect and empties the
//   queue (everything younger is wrong-path).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - branch_resolve_queue_if.slave: push, resolve, flush inputs;
//           occupancy, predictor update, redirect and sticky error outputs
module branch_resolve_queue #(
    parameter int W_BRID = 2,
    parameter int W_ADDR = 32,
    parameter int DEPTH  = 4,
    parameter int W_PTR  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_queue_if.slave  bus
);

    logic [W_BRID-1:0] mem_id [DEPTH];
    logic [W_ADDR-1:0] mem_pc [DEPTH];

    logic [W_PTR-1:0]  head;
    logic [W_PTR-1:0]  tail;
    logic [W_PTR:0]    count;

    logic              full;
    logic              empty;
    logic              push_acc;
    logic              res_acc;
    logic              miss;
    logic              err_set;
    logic [W_BRID-1:0] head_id;
    logic [W_ADDR-1:0] head_pc;

    logic [W_PTR-1:0]  head_nxt;
    logic [W_PTR-1:0]  tail_nxt;
    logic [W_PTR:0]    count_nxt;

    logic              upd_v;
    logic              upd_branch;
    logic [W_BRID-1:0] upd_id;
    logic              mispred;
    logic [W_ADDR-1:0] redirect_pc;
    logic              err;

    assign full    = (count == (W_PTR+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = mem_id[head];
    assign head_pc = mem_pc[head];

    // flush overrides both push and resolve in the same cycle
    assign push_acc = bus.push_v_i && !full  && !bus.flush_i;
    assign res_acc  = bus.res_v_i  && !empty && !bus.flush_i;
    assign miss     = res_acc && (bus.res_taken_i ^ head_id[W_BRID-1]);

    // push-while-full is an error even if a pop frees a slot this cycle
    assign err_set  = (bus.push_v_i && full) || (bus.res_v_i && empty);

    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (bus.flush_i || miss) begin
            // a same-cycle push is wrong-path and is dropped with the rest
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (push_acc) begin
                tail_nxt = tail + W_PTR'(1);
            end
            if (res_acc) begin
                head_nxt = head + W_PTR'(1);
            end
            case ({push_acc, res_acc})
                2'b10:   count_nxt = count + (W_PTR+1)'(1);
                2'b01:   count_nxt = count - (W_PTR+1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    // entry storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_id[tail] <= bus.push_id_i;
            mem_pc[tail] <= bus.push_alt_pc_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_v       <= 1'b0;
            upd_branch  <= 1'b0;
            upd_id      <= '0;
            mispred     <= 1'b0;
            redirect_pc <= '0;
            err         <= 1'b0;
        end else begin
            upd_v   <= res_acc;
            mispred <= miss;
            err     <= err | err_set;
            if (res_acc) begin
                upd_branch <= bus.res_taken_i;
                upd_id     <= head_id;
            end
            if (miss) begin
                redirect_pc <= head_pc;
            end
        end
    end

    assign bus.full_o        = full;
    assign bus.empty_o       = empty;
    assign bus.count_o       = count;
    assign bus.upd_v_o       = upd_v;
    assign bus.upd_branch_o  = upd_branch;
    assign bus.upd_id_o      = upd_id;
    assign bus.mispred_o     = mispred;
    assign bus.redirect_pc_o = redirect_pc;
    assign bus.err_o         = err;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    localparam int W_BRID = 2;
    localparam int W_ADDR = 32;
    localparam int DEPTH  = 4;
    localparam int W_PTR  = 2;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    branch_resolve_queue_if #(.W_BRID(W_BRID), .W_ADDR(W_ADDR), .W_PTR(W_PTR)) bus ();

    branch_resolve_queue #(
        .W_BRID(W_BRID),
        .W_ADDR(W_ADDR),
        .DEPTH (DEPTH),
        .W_PTR (W_PTR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_v_i      = 1'b0;
        bus.push_id_i     = '0;
        bus.push_alt_pc_i = '0;
        bus.res_v_i       = 1'b0;
        bus.res_taken_i   = 1'b0;
        bus.flush_i       = 1'b0;
    endtask

    // ids pushed in steady-state phase, in push order; direction bit = id[1]
    logic [1:0] wrap_ids [12] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00,
                                  2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [1:0] fill_ids [4]  = '{2'b01, 2'b10, 2'b11, 2'b00};

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        idle_inputs();
        repeat (3) step();
        reset = 1'b1;
        step();

        // reset state
        check_val("rst_empty",   32'(bus.empty_o),   32'd1);
        check_val("rst_full",    32'(bus.full_o),    32'd0);
        check_val("rst_count",   32'(bus.count_o),   32'd0);
        check_val("rst_upd_v",   32'(bus.upd_v_o),   32'd0);
        check_val("rst_mispred", 32'(bus.mispred_o), 32'd0);
        check_val("rst_err",     32'(bus.err_o),     32'd0);

        // fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            bus.push_v_i      = 1'b1;
            bus.push_id_i     = fill_ids[i];
            bus.push_alt_pc_i = 32'h100 + 32'(4 * i);
            step();
            check_val("fill_count", 32'(bus.count_o), 32'(i + 1));
        end
        check_val("fill_full",  32'(bus.full_o), 32'd1);
        check_val("fill_err",   32'(bus.err_o),  32'd0);

        // fifth push rejected
        bus.push_id_i     = 2'b11;
        bus.push_alt_pc_i = 32'h110;
        step();
        check_val("ovf_count", 32'(bus.count_o), 32'd4);
        check_val("ovf_err",   32'(bus.err_o),   32'd1);

        // resolve id 01 not taken: correct prediction
        idle_inputs();
        bus.res_v_i     = 1'b1;
        bus.res_taken_i = 1'b0;
        step();
        check_val("r1_upd_v",    32'(bus.upd_v_o),      32'd1);
        check_val("r1_branch",   32'(bus.upd_branch_o), 32'd0);
        check_val("r1_id",       32'(bus.upd_id_o),     32'h1);
        check_val("r1_mispred",  32'(bus.mispred_o),    32'd0);
        check_val("r1_count",    32'(bus.count_o),      32'd3);

        // resolve id 10 not taken: mispredict, same-cycle push dropped
        bus.res_v_i       = 1'b1;
        bus.res_taken_i   = 1'b0;
        bus.push_v_i      = 1'b1;
        bus.push_id_i     = 2'b11;
        bus.push_alt_pc_i = 32'h300;
        step();
        check_val("r2_mispred",  32'(bus.mispred_o),     32'd1);
        check_val("r2_redirect", bus.redirect_pc_o,      32'h104);
        check_val("r2_id",       32'(bus.upd_id_o),      32'h2);
        check_val("r2_upd_v",    32'(bus.upd_v_o),       32'd1);
        check_val("r2_count",    32'(bus.count_o),       32'd0);
        idle_inputs();
        step();
        check_val("r2_mp_pulse", 32'(bus.mispred_o),     32'd0);
        check_val("r2_upd_idle", 32'(bus.upd_v_o),       32'd0);
        check_val("r2_empty",    32'(bus.empty_o),       32'd1);
        check_val("r2_redir_hold", bus.redirect_pc_o,    32'h104);

        // steady state at count 2 with wrap
        for (int i = 0; i < 2; i++) begin
            bus.push_v_i      = 1'b1;
            bus.push_id_i     = wrap_ids[i];
            bus.push_alt_pc_i = 32'h200 + 32'(4 * i);
            step();
        end
        check_val("wr_pre_count", 32'(bus.count_o), 32'd2);
        for (int k = 0; k < 10; k++) begin
            bus.push_v_i      = 1'b1;
            bus.push_id_i     = wrap_ids[k + 2];
            bus.push_alt_pc_i = 32'h200 + 32'(4 * (k + 2));
            bus.res_v_i       = 1'b1;
            bus.res_taken_i   = wrap_ids[k][1];
            step();
            check_val("wr_count",   32'(bus.count_o),      32'd2);
            check_val("wr_upd_v",   32'(bus.upd_v_o),      32'd1);
            check_val("wr_id",      32'(bus.upd_id_o),     32'(wrap_ids[k]));
            check_val("wr_branch",  32'(bus.upd_branch_o), 32'(wrap_ids[k][1]));
            check_val("wr_mispred", 32'(bus.mispred_o),    32'd0);
        end
        idle_inputs();

        // grow to 3, then flush with a concurrent resolve
        bus.push_v_i      = 1'b1;
        bus.push_id_i     = 2'b01;
        bus.push_alt_pc_i = 32'h400;
        step();
        check_val("fl_pre_count", 32'(bus.count_o), 32'd3);
        idle_inputs();
        bus.flush_i     = 1'b1;
        bus.res_v_i     = 1'b1;
        bus.res_taken_i = 1'b1;
        step();
        check_val("fl_count",   32'(bus.count_o),   32'd0);
        check_val("fl_upd_v",   32'(bus.upd_v_o),   32'd0);
        check_val("fl_mispred", 32'(bus.mispred_o), 32'd0);

        // async reset in the middle of a push, no clock edge in between
        idle_inputs();
        bus.push_v_i      = 1'b1;
        bus.push_id_i     = 2'b10;
        bus.push_alt_pc_i = 32'h500;
        step();
        check_val("ar_pre_count", 32'(bus.count_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_count",    32'(bus.count_o),       32'd0);
        check_val("ar_empty",    32'(bus.empty_o),       32'd1);
        check_val("ar_err",      32'(bus.err_o),         32'd0);
        check_val("ar_redirect", bus.redirect_pc_o,      32'h0);
        check_val("ar_upd_v",    32'(bus.upd_v_o),       32'd0);
        check_val("ar_branch",   32'(bus.upd_branch_o),  32'd0);
        check_val("ar_id",       32'(bus.upd_id_o),      32'd0);
        check_val("ar_mispred",  32'(bus.mispred_o),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
